// File: rtl/pdm_level_monitor_pkg.sv
// Shared constants and FSM encoding for the PDM level monitor.
package pdm_level_monitor_pkg;

  localparam int unsigned LevelW         = 8;
  localparam int unsigned Log2WinDefault = 8;
  localparam int unsigned WinLenDefault  = 1 << Log2WinDefault;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFlush   = 2'd1,
    StMeasure = 2'd2
  } state_e;

endpackage

// File: rtl/pdm_window_counter.sv
// Window and ones counters; publishes the completed window count one cycle after its last bit.
module pdm_window_counter
  import pdm_level_monitor_pkg::*;
#(
  parameter int unsigned Log2Win = Log2WinDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             keep_i,
  input  logic             bit_i,
  output logic             last_o,
  output logic             window_done_o,
  output logic [Log2Win:0] count_o
);

  localparam int unsigned WinLen = 1 << Log2Win;

  logic [Log2Win-1:0] win_q, win_d;
  logic [Log2Win:0]   ones_q, ones_d, count_q, count_d, sum;
  logic               done_q, done_d;

  assign last_o = (win_q == Log2Win'(WinLen - 1));
  assign sum    = ones_q + (Log2Win + 1)'(bit_i);

  always_comb begin
    win_d   = '0;
    ones_d  = '0;
    done_d  = 1'b0;
    count_d = count_q;
    if (run_i) begin
      win_d = win_q + Log2Win'(1);
      if (last_o) begin
        // The final bit is folded into the published count; the next window starts empty.
        count_d = sum;
        done_d  = keep_i;
      end else begin
        ones_d = sum;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q   <= '0;
      ones_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      ones_q  <= ones_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign window_done_o = done_q;
  assign count_o       = count_q;

endmodule

// File: rtl/pdm_level_monitor.sv
// Decodes the sigma-delta bitstream into an 8-bit level and tracks settling after DAC steps.
module pdm_level_monitor
  import pdm_level_monitor_pkg::*;
#(
  parameter int unsigned LOG2_WIN   = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned STABLE_WIN = 3
) (
  input  logic       Clk,
  input  logic       resmon,
  input  logic       enable,
  input  logic       DACin,
  input  logic       clr_settle,
  output logic [7:0] level,
  output logic       level_vld,
  output logic       settled,
  output logic       step_err,
  output logic       busy
);

  localparam int unsigned       Shift   = LOG2_WIN - LevelW;
  localparam logic [LevelW-1:0] TolV    = LevelW'(TOL);
  localparam logic [3:0]        StableV = 4'(STABLE_WIN);

  state_e state_q, state_d;

  logic              run, keep, win_last, win_done;
  logic [LOG2_WIN:0] win_count, shifted;
  logic [LevelW-1:0] sat_level, abs_diff;
  logic [LevelW:0]   diff9;

  logic [LevelW-1:0] level_q, level_d, prev_q, prev_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d, settled_q, settled_d, err_q, err_d, first_q, first_d;

  assign run  = enable && (state_q != StIdle);
  assign keep = enable && (state_q == StMeasure);

  pdm_window_counter #(
    .Log2Win(LOG2_WIN)
  ) u_window_counter (
    .clk_i        (Clk),
    .rst_i        (resmon),
    .run_i        (run),
    .keep_i       (keep),
    .bit_i        (DACin),
    .last_o       (win_last),
    .window_done_o(win_done),
    .count_o      (win_count)
  );

  // Only an all-ones stream can reach 256 after scaling.
  assign shifted   = win_count >> Shift;
  assign sat_level = (|shifted[LOG2_WIN:LevelW]) ? '1 : shifted[LevelW-1:0];
  assign diff9     = {1'b0, sat_level} - {1'b0, prev_q};
  assign abs_diff  = diff9[LevelW] ? LevelW'(-diff9) : diff9[LevelW-1:0];

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StFlush;
        StFlush:   if (win_last) state_d = StMeasure;
        StMeasure: state_d = StMeasure;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    level_d   = level_q;
    vld_d     = 1'b0;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    err_d     = err_q;
    first_d   = first_q;

    if (state_q == StFlush && state_d == StMeasure) begin
      first_d = 1'b1;
    end

    if (win_done && enable) begin
      level_d = sat_level;
      vld_d   = 1'b1;
      prev_d  = sat_level;
      first_d = 1'b0;
      // The first window after FLUSH only seeds the comparison reference.
      if (!first_q) begin
        if (abs_diff <= TolV) begin
          if (cnt_q < StableV) cnt_d = cnt_q + 4'd1;
          settled_d = (cnt_d == StableV);
        end else begin
          cnt_d     = '0;
          settled_d = 1'b0;
          if (settled_q) err_d = 1'b1;
        end
      end
    end

    if (clr_settle) begin
      cnt_d     = '0;
      settled_d = 1'b0;
      err_d     = 1'b0;
    end

    if (!enable) begin
      cnt_d     = '0;
      settled_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (resmon) begin
      state_q   <= StIdle;
      level_q   <= '0;
      vld_q     <= 1'b0;
      prev_q    <= '0;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      vld_q     <= vld_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign level     = level_q;
  assign level_vld = vld_q;
  assign settled   = settled_q;
  assign step_err  = err_q;
  assign busy      = (state_q == StFlush) || (state_q == StMeasure);

endmodule

// File: tb/tb_pdm_level_monitor.sv
// Bench for pdm_level_monitor: DAC-model stimulus, window-sum reference model, directed scenarios.
module tb_pdm_level_monitor;

  localparam int W8   = 256;
  localparam int TolM = 1;
  localparam int StbM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resmon = 1'b1, en8 = 1'b0, en10 = 1'b0, DACin = 1'b0, clr = 1'b0;
  logic [7:0] lvl8, lvl10;
  logic vld8, set8, err8, busy8, vld10, set10, err10, busy10;

  int checks = 0;
  int failures = 0;

  // Stimulus source: 0 first-order DAC model, 1 all ones, 2 all zeros, 3 random density.
  int src = 0;
  int dens = 128;
  logic [7:0] code8 = 8'd0;
  logic [7:0] acc = 8'd0;
  logic [8:0] dac_sum;

  pdm_level_monitor dut8 (
    .Clk(clk), .resmon(resmon), .enable(en8), .DACin(DACin), .clr_settle(clr),
    .level(lvl8), .level_vld(vld8), .settled(set8), .step_err(err8), .busy(busy8)
  );

  pdm_level_monitor #(.LOG2_WIN(10)) dut10 (
    .Clk(clk), .resmon(resmon), .enable(en10), .DACin(DACin), .clr_settle(clr),
    .level(lvl10), .level_vld(vld10), .settled(set10), .step_err(err10), .busy(busy10)
  );

  always @(posedge clk) begin
    #2;
    case (src)
      0: begin
        dac_sum = {1'b0, acc} + {1'b0, code8};
        DACin   = dac_sum[8];
        acc     = dac_sum[7:0];
      end
      1: DACin = 1'b1;
      2: DACin = 1'b0;
      default: DACin = ($urandom_range(255) < dens);
    endcase
  end

  // Reference model for dut8: bits since run start, summed per 256-bit window.
  int  m_k = 0, m_ones = 0, m_pend_val = 0, m_level = 0, m_prev = 0, m_cnt = 0, m_r, m_d;
  bit  m_run = 0, m_pend = 0, m_pend_first = 0, m_vld = 0, m_settled = 0, m_err = 0;

  always @(posedge clk) begin
    if (resmon) begin
      m_run = 0; m_k = 0; m_ones = 0; m_pend = 0; m_level = 0; m_prev = 0;
      m_cnt = 0; m_vld = 0; m_settled = 0; m_err = 0;
    end else begin
      m_vld = 0;
      if (m_pend && en8) begin
        m_r = (m_pend_val > 255) ? 255 : m_pend_val;
        m_vld = 1; m_level = m_r;
        m_d = (m_r > m_prev) ? m_r - m_prev : m_prev - m_r;
        if (!m_pend_first) begin
          if (m_d <= TolM) begin
            if (m_cnt < StbM) m_cnt++;
            m_settled = (m_cnt == StbM);
          end else begin
            if (m_settled) m_err = 1;
            m_cnt = 0; m_settled = 0;
          end
        end
        m_prev = m_r;
      end
      m_pend = 0;
      if (clr) begin m_cnt = 0; m_settled = 0; m_err = 0; end
      if (!en8) begin
        m_run = 0; m_cnt = 0; m_settled = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0; m_ones = 0;
      end else begin
        m_ones += int'(DACin);
        m_k++;
        if (m_k % W8 == 0) begin
          if (m_k >= 2 * W8) begin
            m_pend = 1; m_pend_val = m_ones; m_pend_first = (m_k == 2 * W8);
          end
          m_ones = 0;
        end
      end
    end
  end

  task automatic wait_vld8(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (vld8) begin cyc = i; break; end
    end
  endtask

  task automatic wait_vld10(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (vld10) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    resmon = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({lvl8, vld8, set8, err8, busy8} !== 12'h000) begin
      failures++;
      $display("FAIL reset8: got lvl=%0d vld=%b set=%b err=%b busy=%b want all 0",
               lvl8, vld8, set8, err8, busy8);
    end
    checks++;
    if ({lvl10, vld10, set10, err10, busy10} !== 12'h000) begin
      failures++;
      $display("FAIL reset10: got lvl=%0d busy=%b want all 0", lvl10, busy10);
    end
    resmon = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constant();
    int cyc;
    code8 = 8'd40; src = 0;
    en8 = 1'b1;
    wait_vld8(600, cyc);
    checks++;
    if (cyc != 514) begin
      failures++; $display("FAIL first_vld: got cycle %0d want 514", cyc);
    end
    for (int w = 1; w <= 5; w++) begin
      if (w > 1) begin
        wait_vld8(300, cyc);
        checks++;
        if (cyc != 256) begin failures++; $display("FAIL vld_gap: got %0d want 256", cyc); end
      end
      checks++;
      if (lvl8 !== 8'd40) begin failures++; $display("FAIL const_level: got %0d want 40", lvl8); end
      checks++;
      if (set8 !== 1'(w >= 4)) begin
        failures++; $display("FAIL const_settled w%0d: got %b want %b", w, set8, (w >= 4));
      end
      checks++;
      if (err8 !== 1'b0) begin failures++; $display("FAIL const_err: got %b want 0", err8); end
    end
  endtask

  task automatic test_step_no_clr();
    int cyc;
    repeat (128) @(negedge clk);
    code8 = 8'd8;
    for (int w = 0; w < 5; w++) begin
      wait_vld8(300, cyc);
      checks++;
      if (cyc < 0) begin failures++; $display("FAIL step_timeout: got none want level_vld"); end
      checks++;
      if ({lvl8, set8, err8} !== {m_level[7:0], m_settled, m_err}) begin
        failures++;
        $display("FAIL step_model w%0d: got lvl=%0d set=%b err=%b want lvl=%0d set=%b err=%b",
                 w, lvl8, set8, err8, m_level, m_settled, m_err);
      end
      if (w == 0) begin
        checks++;
        if (!(lvl8 > 8'd8 && lvl8 < 8'd40)) begin
          failures++; $display("FAIL step_mid: got %0d want between 8 and 40", lvl8);
        end
      end else begin
        checks++;
        if (lvl8 !== 8'd8) begin failures++; $display("FAIL step_level: got %0d want 8", lvl8); end
      end
      checks++;
      if (err8 !== 1'b1) begin failures++; $display("FAIL step_err w%0d: got %b want 1", w, err8); end
      checks++;
      if (set8 !== 1'(w == 4)) begin
        failures++; $display("FAIL step_settled w%0d: got %b want %b", w, set8, (w == 4));
      end
    end
  endtask

  task automatic step_with_clr(input logic [7:0] to_code, input string tag);
    int cyc;
    repeat (128) @(negedge clk);
    code8 = to_code; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int w = 0; w < 5; w++) begin
      wait_vld8(300, cyc);
      checks++;
      if (err8 !== 1'b0) begin
        failures++; $display("FAIL %s_err w%0d: got %b want 0", tag, w, err8);
      end
      checks++;
      if (set8 !== 1'(w == 4)) begin
        failures++; $display("FAIL %s_settled w%0d: got %b want %b", tag, w, set8, (w == 4));
      end
    end
    checks++;
    if (lvl8 !== to_code) begin
      failures++; $display("FAIL %s_level: got %0d want %0d", tag, lvl8, to_code);
    end
  endtask

  task automatic test_step_clr();
    step_with_clr(8'd40, "clr_up");
    step_with_clr(8'd8, "clr_down");
  endtask

  task automatic test_disable_mid();
    logic [7:0] held;
    repeat (50) @(negedge clk);
    checks++;
    if (set8 !== 1'b1) begin failures++; $display("FAIL dis_pre_settled: got %b want 1", set8); end
    held = lvl8;
    en8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL dis_busy: got %b want 0", busy8); end
    checks++;
    if (lvl8 !== held) begin failures++; $display("FAIL dis_level: got %0d want %0d", lvl8, held); end
    checks++;
    if (set8 !== 1'b0) begin failures++; $display("FAIL dis_settled: got %b want 0", set8); end
  endtask

  task automatic test_saturate();
    int cyc;
    src = 1; en8 = 1'b1;
    wait_vld8(600, cyc);
    wait_vld8(300, cyc);
    checks++;
    if (lvl8 !== 8'd255) begin failures++; $display("FAIL sat_ones: got %0d want 255", lvl8); end
    src = 2;
    wait_vld8(300, cyc);
    wait_vld8(300, cyc);
    checks++;
    if (lvl8 !== 8'd0) begin failures++; $display("FAIL sat_zeros: got %0d want 0", lvl8); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    src = 0; code8 = 8'd77;
    wait_vld8(300, cyc);
    repeat (99) @(negedge clk);
    resmon = 1'b1;
    @(negedge clk);
    resmon = 1'b0;
    checks++;
    if ({lvl8, vld8, set8, err8, busy8} !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid: got lvl=%0d vld=%b set=%b err=%b busy=%b want all 0",
               lvl8, vld8, set8, err8, busy8);
    end
    wait_vld8(600, cyc);
    checks++;
    if (cyc != 514) begin failures++; $display("FAIL rst_restart: got cycle %0d want 514", cyc); end
    checks++;
    if (lvl8 !== 8'd77) begin failures++; $display("FAIL rst_level: got %0d want 77", lvl8); end
  endtask

  task automatic test_log2win10();
    int cyc;
    en8 = 1'b0; code8 = 8'd24; src = 0;
    en10 = 1'b1;
    wait_vld10(2200, cyc);
    checks++;
    if (cyc != 2050) begin failures++; $display("FAIL l10_first: got cycle %0d want 2050", cyc); end
    for (int w = 0; w < 3; w++) begin
      if (w > 0) wait_vld10(1100, cyc);
      checks++;
      if (lvl10 !== 8'd24) begin failures++; $display("FAIL l10_level: got %0d want 24", lvl10); end
    end
    checks++;
    if (err10 !== 1'b0) begin failures++; $display("FAIL l10_err: got %b want 0", err10); end
    en10 = 1'b0;
  endtask

  task automatic test_random();
    en8 = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      int len;
      int pick;
      pick = $urandom_range(9);
      if (pick < 7) begin
        src = 0; code8 = 8'($urandom_range(255)); len = $urandom_range(2500, 600);
      end else if (pick < 9) begin
        src = 3; dens = $urandom_range(256); len = $urandom_range(1000, 300);
      end else begin
        src = 1; len = 700;
      end
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        checks++;
        if ({lvl8, vld8, set8, err8, busy8} !== {m_level[7:0], m_vld, m_settled, m_err, m_run}) begin
          failures++;
          $display("FAIL rand seg%0d: got lvl=%0d vld=%b set=%b err=%b busy=%b want %0d %b %b %b %b",
                   seg, lvl8, vld8, set8, err8, busy8, m_level, m_vld, m_settled, m_err, m_run);
        end
        clr = ($urandom_range(299) == 0);
        if (en8 && $urandom_range(2999) == 0) en8 = 1'b0;
        else if (!en8 && $urandom_range(19) == 0) en8 = 1'b1;
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_step_no_clr();
    test_step_clr();
    test_disable_mid();
    test_saturate();
    test_reset_mid();
    test_log2win10();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdm_level_monitor.md
Name: pdm_level_monitor

Overview:
- Receive-side decoder for the first-order sigma-delta DAC bitstream. It recovers the 8-bit level code from the 1-bit pulse-density stream by counting ones over a fixed window.
- Tracks whether the decoded level has settled after each DAC step. Used on-board to loop back and check the DAC output (threshold stepping table) against the expected code.

Parameters:
- LOG2_WIN, 8, log2 of the decode window length in Clk cycles; legal range 8..12.
- TOL, 1, maximum absolute difference between consecutive window results that still counts as stable.
- STABLE_WIN, 3, consecutive stable windows required to assert settled; legal range 1..15.

Ports:
- Clk  input  1  system clock; also clocks the DAC accumulator.
- resmon  input  1  reset, synchronous, active-high.
- enable  input  1  decoding runs while high; a falling edge returns the block to IDLE.
- DACin  input  1  sigma-delta bitstream, one bit per Clk, synchronous to Clk.
- clr_settle  input  1  one-cycle pulse; restarts settle tracking (issued with each DAC load).
- level  output  8  last decoded level code.
- level_vld  output  1  one-cycle pulse when level updates.
- settled  output  1  level stable for STABLE_WIN windows.
- step_err  output  1  sticky; set when a window differs from the previous one by more than TOL while settled.
- busy  output  1  high in FLUSH or MEASURE.

Behaviour:
- Reset, sampled on the Clk rising edge with resmon=1:
  - level=0, level_vld=0, settled=0, step_err=0, busy=0.
  - Window counter=0, ones counter=0, stable counter=0, previous level=0.
  - State=IDLE.
  - Reset overrides every other input in the same cycle, including mid-window; the partial count is discarded.
- States:
  - IDLE: counters held at 0. enable=1 -> FLUSH next cycle.
  - FLUSH: one full window of 2^LOG2_WIN cycles. DACin is counted but the result is discarded, which absorbs the accumulator phase. At the end of the window -> MEASURE.
  - MEASURE: windows run back-to-back with no gap cycles.
  - enable=0 in any state -> IDLE next cycle. Counters clear. level and step_err are held; settled clears.
- Window:
  - Window counter is LOG2_WIN bits and wraps to 0 after 2^LOG2_WIN-1.
  - Ones counter is LOG2_WIN+1 bits and increments when DACin=1.
  - On the last window cycle, that cycle's DACin bit is included. The counter then restarts at 0, or at 1 if the first bit of the next window is 1; the next window starts on the following cycle.
- Result:
  - r = ones >> (LOG2_WIN-8).
  - If r > 255 (all-ones stream), saturate to 255.
  - The result registers into level in the cycle after the window's last bit. level_vld pulses in that same cycle.
  - Latency: from the last sampled bit to level valid = 1 Clk.
- Settle tracking, evaluated on each level_vld:
  - d = |r - previous level|. previous level <= r.
  - If d <= TOL, stable counter increments, saturating at STABLE_WIN. settled=1 when the counter reaches STABLE_WIN.
  - If d > TOL, stable counter=0 and settled=0. If settled was 1 in that same cycle, step_err <= 1.
  - The first MEASURE window after FLUSH only loads previous level; stable counter stays 0.
- clr_settle:
  - Stable counter=0 and settled=0. step_err is cleared. The window is not restarted.
  - If it coincides with level_vld, clr_settle wins: counter=0, but previous level still updates to r.
- step_err clears only on reset or clr_settle.
- Arithmetic: all unsigned. The difference uses a 9-bit subtract and conditional negate.

Decomposition:
- Shared package holds:
  - state encoding constants for IDLE/FLUSH/MEASURE;
  - the level width constant (8);
  - a window-length localparam derived from LOG2_WIN.
- One sub-module, pdm_window_counter, holds the window and ones counters. It outputs window_done and the raw count.
- The top level holds the FSM, saturation and settle tracking.

Test Plan:
- Constant stream from the DAC model with input 40, LOG2_WIN=8, enable raised at t0:
  - first level_vld at t0+1+256+256+1;
  - level=40 every window;
  - settled after 1+3 MEASURE windows;
  - step_err=0.
- Step 40 -> 8 while settled, without clr_settle:
  - the window containing the step gives an intermediate value;
  - d > TOL sets step_err=1 and settled=0;
  - after 3 stable windows at 8, settled=1 again and step_err stays 1.
- Same step with clr_settle pulsed at the DAC load:
  - step_err=0 throughout;
  - settled returns after the settle windows at level=8.
- All-ones DACin:
  - level=255 (saturated);
  - all-zeros DACin gives level=0.
- LOG2_WIN=10 with input 24:
  - ones=96 per window;
  - level=24.
- resmon asserted mid-window (cycle 100 of MEASURE):
  - next cycle all outputs at reset values and state IDLE;
  - with enable held high, FLUSH restarts and there is no level_vld for 512 cycles.
- Also, in the same bench: enable deasserted mid-window -> busy=0 next cycle, level held, settled=0.
